barrier_sync_unit: RTL and testbench
====================================

Name: barrier_sync_unit

Overview:
Upstream of warp_scheduler; tracks warp arrivals at named barriers and drives the scheduler's barrier interface.
- Raises a per-warp stall pulse when a warp arrives.
- Issues a single release mask once every participating warp of that barrier has arrived.
- Participation masks are programmed per barrier by the kernel-launch logic.

Parameters:
NUM_WARPS, 32, number of warp slots; equals the scheduler's NUM_WARPS
NUM_BARRIERS, 16, number of independent named barriers
WARP_ID_W, 6, warp id width
BAR_ID_W, 4, barrier id width; must satisfy 2**BAR_ID_W >= NUM_BARRIERS

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  program a participation mask this cycle
cfg_barrier_id  input  BAR_ID_W  barrier being programmed
cfg_warp_mask  input  NUM_WARPS  participating warps
arrive_valid  input  1  a warp executed BAR.SYNC
arrive_ready  output  1  arrival accepted this cycle
arrive_warp_id  input  WARP_ID_W  arriving warp
arrive_barrier_id  input  BAR_ID_W  target barrier
flush_valid  input  1  abort one barrier
flush_barrier_id  input  BAR_ID_W  barrier to abort
barrier_stall  output  1  registered pulse: a warp must stall
barrier_warp_mask  output  NUM_WARPS  one-hot mask of the stalling warp
barrier_release_valid  output  1  registered pulse: release warps
barrier_release_warp_mask  output  NUM_WARPS  warps to release
err_pulse  output  1  illegal arrival or config rejected
err_code  output  2  1=non-participant, 2=duplicate arrival, 3=cfg while busy
barriers_completed  output  32  count of barriers released

Behaviour:
Reset values:
- All outputs are 0, except arrive_ready, which is 1.
- All participation masks and arrived masks are 0; every barrier is IDLE.

Per-barrier state: IDLE (arrived==0) or COLLECTING (arrived!=0). The state is derived from the arrived mask; there is no separate encoding.

Arrival handshake:
- Accepted when arrive_valid && arrive_ready.
- arrive_ready is 0 only in the cycle when flush_valid targets the same barrier as arrive_barrier_id.
- Let b = arrive_barrier_id and w = arrive_warp_id. Arrival is legal when part[b][w]==1 and arrived[b][w]==0.
  - Legal, non-final (arrived[b] | (1<<w)) != part[b]: set arrived[b][w]. Next cycle: barrier_stall=1, barrier_warp_mask=1<<w.
  - Legal, final (equals part[b]): clear arrived[b] to 0 and do not assert barrier_stall. Next cycle: barrier_release_valid=1, barrier_release_warp_mask=part[b]; barriers_completed increments.
  - part[b][w]==0, including part[b]==0: ignore the arrival; next cycle err_pulse=1, err_code=1.
  - arrived[b][w]==1: ignore the arrival; next cycle err_pulse=1, err_code=2.
- b >= NUM_BARRIERS is treated as a non-participant (code 1).
- Output latency is 1 cycle from acceptance. All pulses last exactly one cycle.
- Single-participant barrier: the arrival is final immediately, so a release occurs with no stall.

Config:
- When arrived[cfg_barrier_id]==0 (including the same cycle a final arrival clears it), write part. Same-cycle arrival at that barrier uses the old part.
- Otherwise ignore the write; err code 3.
- Arrival error takes priority over cfg error if both occur in one cycle.

Flush:
- Next cycle: barrier_release_valid=1, barrier_release_warp_mask=arrived[b]; arrived[b] cleared.
- No pulse if arrived[b]==0.
- barriers_completed is not incremented.

Simultaneous events:
- Only one arrival is accepted per cycle, so at most one completion plus one flush can occur in a cycle.
- If a flush and a completion on different barriers coincide, the release mask is the OR of both and a single release pulse is issued. The counter still increments for the completion.

Counter: barriers_completed wraps at 2**32.

Reset mid-operation: all arrivals are discarded, and pending pulses are dropped without being emitted.

Decomposition:
Package barrier_types: BAR_ID_W, err code enum (ERR_NONE, ERR_NONPART, ERR_DUP, ERR_CFG_BUSY), barrier_entry_t {part, arrived}.

One sub-module, barrier_entry: holds one barrier's part and arrived masks and outputs complete/illegal flags. It is instantiated NUM_BARRIERS times. The top level handles decode, output registers and the counter.

Test Plan:
- cfg b0 mask 0x0000000F; warps 0,1,2 arrive → three stall pulses with masks 0x1, 0x2, 0x4. Warp 3 arrives → release_valid=1, mask 0x0000000F, no stall, barriers_completed=1.
- cfg b1 mask 0x3; warp 0 arrives twice → stall 0x1, then err_pulse code 2; arrived[1] stays 0x1.
- Warp 5 arrives at b2 with part[2]=0 → err code 1, no stall/release. cfg b1 while COLLECTING → err code 3, mask unchanged.
- cfg b3 mask 0xF0; warps 4,5 arrive; flush b3 → release mask 0x30, counter unchanged; b3 IDLE, so a new cfg is accepted.
- Completion of b0 and flush of b1 in the same cycle → one release pulse with the OR mask; counter +1. Flush and arrival to the same barrier in the same cycle → arrive_ready=0 that cycle.
- Assert rst_n low while b0 is COLLECTING (arrived=0x3) → outputs 0 immediately; after reset, warp 0 arriving at b0 gives err code 1 (part cleared).

Source files
------------

// File: rtl/barrier_sync_unit_pkg.sv
// ---------------------------------------------------------------------------
// barrier_types
//   Shared sizing constants, error codes and the per-barrier state record for
//   the barrier_sync_unit slice. BAR_ID_W must satisfy
//   2**BAR_ID_W >= NUM_BARRIERS.
// ---------------------------------------------------------------------------
package barrier_types;

    localparam int NUM_WARPS    = 32;
    localparam int NUM_BARRIERS = 16;
    localparam int WARP_ID_W    = 6;
    localparam int BAR_ID_W     = 4;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_NONPART  = 2'd1,
        ERR_DUP      = 2'd2,
        ERR_CFG_BUSY = 2'd3
    } err_code_e;

    typedef logic [NUM_WARPS-1:0] warp_mask_t;

    typedef struct packed {
        warp_mask_t part;     // participating warps
        warp_mask_t arrived;  // warps already waiting; zero means IDLE
    } barrier_entry_t;

    // One-hot of a warp id; ids beyond the last warp slot give an all-zero
    // mask, which every barrier then sees as a non-participant.
    function automatic warp_mask_t warp_onehot(input logic [WARP_ID_W-1:0] id);
        warp_mask_t m;
        m = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            m[i] = (id == WARP_ID_W'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/barrier_sync_unit_entry.sv
// ---------------------------------------------------------------------------
// barrier_entry
//   State of one named barrier: participation mask and arrived mask. Flags
//   describe what the currently presented arrival would do to this barrier;
//   the top level only trusts them for the barrier the arrival addresses.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cfg_sel_i         config write addressed to this barrier
//   cfg_mask_i        new participation mask
//   arrive_sel_i      accepted arrival addressed to this barrier
//   arrive_onehot_i   one-hot of the arriving warp
//   flush_sel_i       abort this barrier
//   state_o           current {part, arrived}
//   nonpart_o         arriving warp does not participate
//   dup_o             arriving warp already arrived
//   final_o           arriving warp would complete the barrier
//   cfg_busy_o        config write rejected because the barrier is collecting
// ---------------------------------------------------------------------------
module barrier_entry
    import barrier_types::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cfg_sel_i,
    input  warp_mask_t     cfg_mask_i,
    input  logic           arrive_sel_i,
    input  warp_mask_t     arrive_onehot_i,
    input  logic           flush_sel_i,
    output barrier_entry_t state_o,
    output logic           nonpart_o,
    output logic           dup_o,
    output logic           final_o,
    output logic           cfg_busy_o
);

    warp_mask_t part_q, part_d;
    warp_mask_t arrived_q, arrived_d;
    logic       is_part;
    logic       legal;
    logic       cfg_ok;

    always_comb begin
        is_part    = |(part_q & arrive_onehot_i);
        nonpart_o  = !is_part;
        dup_o      = is_part && |(arrived_q & arrive_onehot_i);
        legal      = is_part && !dup_o;
        final_o    = legal && ((arrived_q | arrive_onehot_i) == part_q);

        // A final arrival in the same cycle frees the barrier for a new mask;
        // the arrival itself was judged against the old mask above.
        cfg_ok     = (arrived_q == '0) || (arrive_sel_i && final_o);
        cfg_busy_o = cfg_sel_i && !cfg_ok;

        part_d = part_q;
        if (cfg_sel_i && cfg_ok) begin
            part_d = cfg_mask_i;
        end

        // Flush and an accepted arrival never target the same barrier.
        arrived_d = arrived_q;
        if (flush_sel_i) begin
            arrived_d = '0;
        end else if (arrive_sel_i && legal) begin
            arrived_d = final_o ? '0 : (arrived_q | arrive_onehot_i);
        end

        state_o = '{part: part_q, arrived: arrived_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_q    <= '0;
            arrived_q <= '0;
        end else begin
            part_q    <= part_d;
            arrived_q <= arrived_d;
        end
    end

endmodule

// File: rtl/barrier_sync_unit.sv
// ---------------------------------------------------------------------------
// barrier_sync_unit
//   Tracks warp arrivals at named barriers. Each accepted arrival produces,
//   one cycle later, exactly one of: a stall pulse for that warp, a release
//   pulse for the whole barrier, or an error pulse. Flushes release whatever
//   has arrived so far; a flush and a completion in one cycle merge into one
//   release pulse.
// Handshake: an arrival transfers when arrive_valid && arrive_ready.
//   arrive_ready drops only while a flush targets the same barrier.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cfg_*                       participation mask programming
//   arrive_*                    warp arrival handshake
//   flush_*                     abort one barrier
//   barrier_stall/_warp_mask    registered stall pulse, one-hot warp
//   barrier_release_*           registered release pulse and warp mask
//   err_pulse/err_code          registered error pulse and cause
//   barriers_completed          wrapping count of completed barriers
// ---------------------------------------------------------------------------
module barrier_sync_unit
    import barrier_types::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid,
    input  logic [BAR_ID_W-1:0]  cfg_barrier_id,
    input  logic [NUM_WARPS-1:0] cfg_warp_mask,
    input  logic                 arrive_valid,
    output logic                 arrive_ready,
    input  logic [WARP_ID_W-1:0] arrive_warp_id,
    input  logic [BAR_ID_W-1:0]  arrive_barrier_id,
    input  logic                 flush_valid,
    input  logic [BAR_ID_W-1:0]  flush_barrier_id,
    output logic                 barrier_stall,
    output logic [NUM_WARPS-1:0] barrier_warp_mask,
    output logic                 barrier_release_valid,
    output logic [NUM_WARPS-1:0] barrier_release_warp_mask,
    output logic                 err_pulse,
    output logic [1:0]           err_code,
    output logic [31:0]          barriers_completed
);

    logic [NUM_BARRIERS-1:0] arr_dec, cfg_dec, flush_dec;
    logic [NUM_BARRIERS-1:0] nonpart_w, dup_w, final_w, cfg_busy_w;
    barrier_entry_t          ent_w [NUM_BARRIERS];
    warp_mask_t              arrive_onehot;
    logic                    accept;

    logic       stall_q, stall_d;
    warp_mask_t wmask_q, wmask_d;
    logic       rel_q, rel_d;
    warp_mask_t rmask_q, rmask_d;
    logic       err_q, err_d;
    err_code_e  code_q, code_d;
    logic [31:0] cnt_q, cnt_d;

    warp_mask_t arr_part, flush_arrived;
    logic       arr_nonpart, arr_dup, arr_final;

    assign arrive_ready  = !(flush_valid && (flush_barrier_id == arrive_barrier_id));
    assign accept        = arrive_valid && arrive_ready;
    assign arrive_onehot = warp_onehot(arrive_warp_id);

    for (genvar g = 0; g < NUM_BARRIERS; g++) begin : g_bar
        assign arr_dec[g]   = (arrive_barrier_id == BAR_ID_W'(g));
        assign cfg_dec[g]   = (cfg_barrier_id == BAR_ID_W'(g));
        assign flush_dec[g] = (flush_barrier_id == BAR_ID_W'(g));

        barrier_entry u_entry (
            .clk             (clk),
            .rst_n           (rst_n),
            .cfg_sel_i       (cfg_valid && cfg_dec[g]),
            .cfg_mask_i      (cfg_warp_mask),
            .arrive_sel_i    (accept && arr_dec[g]),
            .arrive_onehot_i (arrive_onehot),
            .flush_sel_i     (flush_valid && flush_dec[g]),
            .state_o         (ent_w[g]),
            .nonpart_o       (nonpart_w[g]),
            .dup_o           (dup_w[g]),
            .final_o         (final_w[g]),
            .cfg_busy_o      (cfg_busy_w[g])
        );
    end

    always_comb begin
        arr_part      = '0;
        flush_arrived = '0;
        for (int i = 0; i < NUM_BARRIERS; i++) begin
            if (arr_dec[i])   arr_part      = arr_part | ent_w[i].part;
            if (flush_dec[i]) flush_arrived = flush_arrived | ent_w[i].arrived;
        end
        // An id that decodes to no barrier counts as a non-participant.
        arr_nonpart = !(|arr_dec) || |(arr_dec & nonpart_w);
        arr_dup     = |(arr_dec & dup_w);
        arr_final   = |(arr_dec & final_w);

        stall_d = 1'b0;
        wmask_d = '0;
        rmask_d = '0;
        err_d   = 1'b0;
        code_d  = ERR_NONE;
        cnt_d   = cnt_q;

        if (accept) begin
            if (arr_nonpart) begin
                err_d  = 1'b1;
                code_d = ERR_NONPART;
            end else if (arr_dup) begin
                err_d  = 1'b1;
                code_d = ERR_DUP;
            end else if (arr_final) begin
                rmask_d = arr_part;
                cnt_d   = cnt_q + 32'd1;
            end else begin
                stall_d = 1'b1;
                wmask_d = arrive_onehot;
            end
        end

        if (flush_valid) begin
            rmask_d = rmask_d | flush_arrived;
        end
        rel_d = |rmask_d;

        // Arrival errors win over a rejected config in the same cycle.
        if (!err_d && |cfg_busy_w) begin
            err_d  = 1'b1;
            code_d = ERR_CFG_BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 1'b0;
            wmask_q <= '0;
            rel_q   <= 1'b0;
            rmask_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            cnt_q   <= '0;
        end else begin
            stall_q <= stall_d;
            wmask_q <= wmask_d;
            rel_q   <= rel_d;
            rmask_q <= rmask_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

    assign barrier_stall             = stall_q;
    assign barrier_warp_mask         = wmask_q;
    assign barrier_release_valid     = rel_q;
    assign barrier_release_warp_mask = rmask_q;
    assign err_pulse                 = err_q;
    assign err_code                  = code_q;
    assign barriers_completed        = cnt_q;

endmodule

// File: tb/tb_barrier_sync_unit.sv
// ---------------------------------------------------------------------------
// tb_barrier_sync_unit
//   Directed stimulus for barrier_sync_unit. Each stimulus cycle that should
//   produce a pulse pushes the expected output tuple
//   {stall, warp_mask, release, release_mask, err, code, completed}; a
//   monitor pops one tuple for every cycle in which the DUT shows a pulse.
// ---------------------------------------------------------------------------
module tb_barrier_sync_unit;

    localparam int W = 1 + 32 + 1 + 32 + 1 + 2 + 32;

    logic        clk;
    logic        rst_n;
    logic        cfg_valid;
    logic [3:0]  cfg_barrier_id;
    logic [31:0] cfg_warp_mask;
    logic        arrive_valid;
    logic        arrive_ready;
    logic [5:0]  arrive_warp_id;
    logic [3:0]  arrive_barrier_id;
    logic        flush_valid;
    logic [3:0]  flush_barrier_id;
    logic        barrier_stall;
    logic [31:0] barrier_warp_mask;
    logic        barrier_release_valid;
    logic [31:0] barrier_release_warp_mask;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [31:0] barriers_completed;

    logic [W-1:0] exp_q[$];
    int compared = 0;
    int failed   = 0;

    barrier_sync_unit dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .cfg_valid                 (cfg_valid),
        .cfg_barrier_id            (cfg_barrier_id),
        .cfg_warp_mask             (cfg_warp_mask),
        .arrive_valid              (arrive_valid),
        .arrive_ready              (arrive_ready),
        .arrive_warp_id            (arrive_warp_id),
        .arrive_barrier_id         (arrive_barrier_id),
        .flush_valid               (flush_valid),
        .flush_barrier_id          (flush_barrier_id),
        .barrier_stall             (barrier_stall),
        .barrier_warp_mask         (barrier_warp_mask),
        .barrier_release_valid     (barrier_release_valid),
        .barrier_release_warp_mask (barrier_release_warp_mask),
        .err_pulse                 (err_pulse),
        .err_code                  (err_code),
        .barriers_completed        (barriers_completed)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        cfg_valid         = 1'b0;
        cfg_barrier_id    = '0;
        cfg_warp_mask     = '0;
        arrive_valid      = 1'b0;
        arrive_warp_id    = '0;
        arrive_barrier_id = '0;
        flush_valid       = 1'b0;
        flush_barrier_id  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic set_cfg(input int b, input logic [31:0] m);
        cfg_valid      = 1'b1;
        cfg_barrier_id = 4'(b);
        cfg_warp_mask  = m;
    endtask

    task automatic set_arrive(input int w, input int b);
        arrive_valid      = 1'b1;
        arrive_warp_id    = 6'(w);
        arrive_barrier_id = 4'(b);
    endtask

    task automatic set_flush(input int b);
        flush_valid      = 1'b1;
        flush_barrier_id = 4'(b);
    endtask

    task automatic exp_stall(input logic [31:0] wm, input logic [31:0] cnt);
        exp_q.push_back({1'b1, wm, 1'b0, 32'h0, 1'b0, 2'd0, cnt});
    endtask

    task automatic exp_rel(input logic [31:0] rm, input logic [31:0] cnt);
        exp_q.push_back({1'b0, 32'h0, 1'b1, rm, 1'b0, 2'd0, cnt});
    endtask

    task automatic exp_err(input logic [1:0] code, input logic [31:0] cnt);
        exp_q.push_back({1'b0, 32'h0, 1'b0, 32'h0, 1'b1, code, cnt});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] got;
        logic [W-1:0] e;
        if (rst_n && (barrier_stall || barrier_release_valid || err_pulse)) begin
            got = {barrier_stall, barrier_warp_mask, barrier_release_valid,
                   barrier_release_warp_mask, err_pulse, err_code, barriers_completed};
            compared++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL unexpected_pulse at %0t: got %h expected none", $time, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    failed++;
                    $display("FAIL pulse at %0t: got st=%0b wm=%08h rel=%0b rm=%08h err=%0b code=%0d cnt=%0d expected st=%0b wm=%08h rel=%0b rm=%08h err=%0b code=%0d cnt=%0d",
                             $time, got[100], got[99:68], got[67], got[66:35], got[34], got[33:32], got[31:0],
                             e[100], e[99:68], e[67], e[66:35], e[34], e[33:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_stall", {31'h0, barrier_stall}, 32'h0);
        check("reset_warp_mask", barrier_warp_mask, 32'h0);
        check("reset_release", {31'h0, barrier_release_valid}, 32'h0);
        check("reset_release_mask", barrier_release_warp_mask, 32'h0);
        check("reset_err", {29'h0, err_pulse, err_code}, 32'h0);
        check("reset_count", barriers_completed, 32'h0);
        check("reset_ready", {31'h0, arrive_ready}, 32'h1);
        rst_n = 1'b1;
        tick();

        // Four-warp barrier: three stalls, then a release.
        set_cfg(0, 32'h0000_000F);                     tick();
        set_arrive(0, 0); exp_stall(32'h1, 0);         tick();
        set_arrive(1, 0); exp_stall(32'h2, 0);         tick();
        set_arrive(2, 0); exp_stall(32'h4, 0);         tick();
        set_arrive(3, 0); exp_rel(32'hF, 1);           tick();
        tick();

        // Duplicate arrival, non-participant, config while busy.
        set_cfg(1, 32'h3);                             tick();
        set_arrive(0, 1); exp_stall(32'h1, 1);         tick();
        set_arrive(0, 1); exp_err(2'd2, 1);            tick();
        set_arrive(5, 2); exp_err(2'd1, 1);            tick();
        set_cfg(1, 32'hFF); exp_err(2'd3, 1);          tick();
        set_arrive(1, 1); exp_rel(32'h3, 2);           tick();
        tick();

        // Flush mid-collection, then reprogram as a single-participant barrier.
        set_cfg(3, 32'hF0);                            tick();
        set_arrive(4, 3); exp_stall(32'h10, 2);        tick();
        set_arrive(5, 3); exp_stall(32'h20, 2);        tick();
        set_flush(3); exp_rel(32'h30, 2);              tick();
        set_cfg(3, 32'h1);                             tick();
        set_arrive(0, 3); exp_rel(32'h1, 3);           tick();
        tick();

        // Completion on b0 and flush of b1 merge into one release.
        set_cfg(0, 32'h3);                             tick();
        set_cfg(1, 32'hC);                             tick();
        set_arrive(0, 0); exp_stall(32'h1, 3);         tick();
        set_arrive(2, 1); exp_stall(32'h4, 3);         tick();
        set_arrive(1, 0); set_flush(1);
        #1 check("ready_diff_barrier", {31'h0, arrive_ready}, 32'h1);
        exp_rel(32'h7, 4);                             tick();
        tick();

        // Flush and arrival on the same barrier: arrival is refused.
        set_cfg(4, 32'h3);                             tick();
        set_arrive(0, 4); exp_stall(32'h1, 4);         tick();
        set_arrive(1, 4); set_flush(4);
        #1 check("ready_collision", {31'h0, arrive_ready}, 32'h0);
        exp_rel(32'h1, 4);                             tick();
        set_arrive(1, 4); exp_stall(32'h2, 4);         tick();
        // Arrival error outranks config error.
        set_arrive(7, 2); set_cfg(4, 32'h55); exp_err(2'd1, 4); tick();
        // Config accepted in the same cycle a final arrival clears the barrier.
        set_arrive(0, 4); set_cfg(4, 32'h80); exp_rel(32'h3, 5); tick();
        set_arrive(7, 4); exp_rel(32'h80, 6);          tick();
        tick();

        // Reset while collecting: outputs clear at once, config is lost.
        set_cfg(0, 32'hF);                             tick();
        set_arrive(0, 0); exp_stall(32'h1, 6);         tick();
        set_arrive(1, 0); exp_stall(32'h2, 6);         tick();
        #1 check("pre_reset_stall", {31'h0, barrier_stall}, 32'h1);
        set_arrive(2, 0);
        rst_n = 1'b0;
        #1 check("async_reset_stall", {31'h0, barrier_stall}, 32'h0);
        check("async_reset_warp_mask", barrier_warp_mask, 32'h0);
        check("async_reset_count", barriers_completed, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        set_arrive(0, 0); exp_err(2'd1, 0);            tick();
        repeat (3) tick();

        check("queue_drained", exp_q.size(), 32'h0);
        check("final_count", barriers_completed, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
